// File: rtl/inc_pulse_gen_pkg.sv
// Shared definitions for the inc pulse burst generator: state encodings,
// default counter width and the phase-timer width helper.
package inc_pulse_gen_pkg;

  // Matches the width of the downstream 10-bit event counter.
  localparam int unsigned CNT_W_DEFAULT = 10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    StIdle = S_IDLE,
    StHigh = S_HIGH,
    StLow  = S_LOW,
    StDone = S_DONE
  } state_e;

  // Timer holds (cycles - 1), so clog2 of the longer phase is enough; never below 1 bit.
  function automatic int unsigned timer_width(input int unsigned hi, input int unsigned lo);
    int unsigned m;
    int unsigned w;
    m = (hi > lo) ? hi : lo;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/inc_pulse_gen_phase.sv
// Loadable down-counter shared by the HIGH and LOW phases. Expires when it
// reaches zero and then holds there until reloaded.
module phase_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/inc_pulse_gen.sv
// Burst generator for the event counter's inc input: emits exactly `count`
// pulses of HI_CYC high / LO_CYC low, then strobes done for one cycle.
module inc_pulse_gen
  import inc_pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEFAULT,
  parameter int unsigned HI_CYC = 6,
  parameter int unsigned LO_CYC = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             abort,
  output logic             inc,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] remaining
);

  localparam int unsigned TW = timer_width(HI_CYC, LO_CYC);
  localparam logic [TW-1:0] HiLoad = TW'(HI_CYC - 1);
  localparam logic [TW-1:0] LoLoad = TW'(LO_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             abort_pend_q, abort_pend_d;
  logic             inc_q, inc_d;
  logic             tmr_load;
  logic [TW-1:0]    tmr_value;
  logic             tmr_expire;

  phase_timer #(
    .W (TW)
  ) u_phase_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tmr_load),
    .value  (tmr_value),
    .expire (tmr_expire)
  );

  // Next-state, remaining count, pending-abort and timer reload decisions.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    abort_pend_d = abort_pend_q;
    tmr_load     = 1'b0;
    tmr_value    = HiLoad;
    unique case (state_q)
      StIdle: begin
        abort_pend_d = 1'b0;
        if (start && !abort) begin
          rem_d = count;
          if (count != '0) begin
            state_d   = StHigh;
            tmr_load  = 1'b1;
            tmr_value = HiLoad;
          end else begin
            state_d = StDone;
          end
        end
      end
      StHigh: begin
        // An abort mid-pulse is deferred so the pulse and its low gap stay full width.
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        if (tmr_expire) begin
          if (rem_q != '0) begin
            rem_d = rem_q - CNT_W'(1);
          end
          state_d   = StLow;
          tmr_load  = 1'b1;
          tmr_value = LoLoad;
        end
      end
      StLow: begin
        if (abort && !abort_pend_q) begin
          state_d      = StDone;
          abort_pend_d = 1'b0;
        end else if (tmr_expire) begin
          abort_pend_d = 1'b0;
          if (abort_pend_q || (rem_q == '0)) begin
            state_d = StDone;
          end else begin
            state_d   = StHigh;
            tmr_load  = 1'b1;
            tmr_value = HiLoad;
          end
        end
      end
      StDone: begin
        abort_pend_d = 1'b0;
        state_d      = StIdle;
      end
    endcase
  end

  // inc is registered from the next state so it never glitches.
  always_comb begin
    inc_d = (state_d == StHigh);
  end

  // State, counters and the inc flop; reset drops inc immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rem_q        <= '0;
      abort_pend_q <= 1'b0;
      inc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      abort_pend_q <= abort_pend_d;
      inc_q        <= inc_d;
    end
  end

  assign inc       = inc_q;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign remaining = rem_q;

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Self-checking bench for inc_pulse_gen with HI_CYC=2, LO_CYC=3. Expected
// per-cycle outputs come from burst timeline arithmetic.
module tb_inc_pulse_gen;

  localparam int HI = 2;
  localparam int LO = 3;
  localparam int P  = HI + LO;
  localparam int CW = 10;

  typedef struct packed {
    logic          inc;
    logic          busy;
    logic          done;
    logic [CW-1:0] rem;
  } obs_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] count = '0;
  logic          abort = 1'b0;
  logic          inc;
  logic          busy;
  logic          done;
  logic [CW-1:0] remaining;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  logic [CW-1:0] last_rem = '0;

  inc_pulse_gen #(
    .CNT_W  (CW),
    .HI_CYC (HI),
    .LO_CYC (LO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count     (count),
    .abort     (abort),
    .inc       (inc),
    .busy      (busy),
    .done      (done),
    .remaining (remaining)
  );

  always #5 clk = ~clk;

  // Downstream counter: counts rising edges of inc.
  always @(posedge inc) pulse_cnt = pulse_cnt + 1;

  // Pulses whose high phase has fully ended within the first t cycles of a burst.
  function automatic int completed(input int t);
    if (t < HI) return 0;
    return (t - HI) / P + 1;
  endfunction

  // Launch a burst of n pulses. ka: cycle in which abort is held (0 = none).
  // ign_k: cycle in which a stray start with count=7 is presented (0 = none).
  // stop_k: stop after checking this cycle (0 = run to idle).
  task automatic run_burst(input int n, input int ka, input int ign_k, input int stop_k,
                           input string name);
    int   e;
    int   last;
    int   base;
    int   t;
    obs_t ex;
    obs_t ob;
    e = n * P;
    if (n != 0 && ka > 0 && ka <= e) begin
      if ((ka - 1) % P < HI) e = ((ka - 1) / P + 1) * P;
      else e = ka;
    end
    base  = pulse_cnt;
    count = CW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count = CW'($urandom);
    last  = (stop_k > 0) ? stop_k : e + 2;
    for (int k = 1; k <= last; k++) begin
      t       = (k - 1 < e) ? k - 1 : e;
      ex.inc  = (k <= e) && ((k - 1) % P < HI);
      ex.busy = (k <= e + 1);
      ex.done = (k == e + 1);
      ex.rem  = CW'(n - completed(t));
      ob      = {inc, busy, done, remaining};
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL %s cycle %0d: got inc=%b busy=%b done=%b rem=%0d, want inc=%b busy=%b done=%b rem=%0d",
                 name, k, ob.inc, ob.busy, ob.done, ob.rem, ex.inc, ex.busy, ex.done, ex.rem);
      end
      if (k < last) begin
        abort = (k == ka);
        start = (k == ign_k);
        if (k == ign_k) count = 10'd7;
        @(negedge clk);
      end
    end
    start = 1'b0;
    abort = 1'b0;
    last_rem = CW'(n - completed(e));
    if (stop_k == 0) begin
      checks++;
      if (pulse_cnt - base != completed(e)) begin
        errors++;
        $display("FAIL %s pulse total: got %0d, want %0d", name, pulse_cnt - base, completed(e));
      end
    end
  endtask

  task automatic test_reset();
    obs_t ob;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    ob = {inc, busy, done, remaining};
    checks++;
    if (ob !== '0) begin
      errors++;
      $display("FAIL reset_held: got %h, want 0", ob);
    end
    rst_n = 1'b1;
    @(negedge clk);
    ob = {inc, busy, done, remaining};
    checks++;
    if (ob !== '0) begin
      errors++;
      $display("FAIL reset_released: got %h, want 0", ob);
    end
    last_rem = '0;
  endtask

  task automatic test_basic();
    run_burst(5, 0, 0, 0, "basic_5");
  endtask

  task automatic test_zero_count();
    run_burst(0, 0, 0, 0, "zero_count");
  endtask

  task automatic test_abort();
    // Cycle P+1 is the first cycle of the second high phase.
    run_burst(10, P + 1, 0, 0, "abort_in_high");
    // Abort in the first cycle of a low phase ends the burst on the next edge.
    run_burst(6, HI + 1, 0, 0, "abort_in_low");
  endtask

  task automatic test_back_to_back();
    run_burst(4, 0, 7, 0, "start_mid_burst");
    run_burst(3, 0, 3 * P + 1, 0, "start_during_done");
  endtask

  task automatic test_start_abort_idle();
    obs_t ob;
    obs_t ex;
    count = 10'd9;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    ex = {1'b0, 1'b0, 1'b0, last_rem};
    for (int k = 0; k < 3; k++) begin
      ob = {inc, busy, done, remaining};
      checks++;
      if (ob !== ex) begin
        errors++;
        $display("FAIL start_with_abort cycle %0d: got %h, want %h", k, ob, ex);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    obs_t ob;
    run_burst(1023, 0, 0, 5 * P + 1, "max_before_reset");
    #2;
    rst_n = 1'b0;
    #1;
    ob = {inc, busy, done, remaining};
    checks++;
    if (ob !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h, want 0", ob);
    end
    @(negedge clk);
    rst_n = 1'b1;
    last_rem = '0;
    @(negedge clk);
    run_burst(1023, 0, 0, 0, "max_after_reset");
  endtask

  task automatic test_random();
    int n;
    int ka;
    for (int i = 0; i < 8; i++) begin
      n  = $urandom_range(0, 12);
      ka = 0;
      if (n > 0 && $urandom_range(0, 1) == 1) ka = $urandom_range(1, n * P);
      run_burst(n, ka, 0, 0, "random_burst");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_count();
    test_abort();
    test_back_to_back();
    test_start_abort_idle();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
